// File: rtl/password_cracker_engine_if.sv
// password_cracker_engine_if: start/busy/done job handshake and result bus for one search engine.
// tried_count is present only when PWC_PROGRESS_COUNT_EN is defined.
interface password_cracker_engine_if #(
    parameter int NUM_CHARS = 4,
    parameter int SYM_W     = 6
);
    logic                       start;
    logic [8*NUM_CHARS-1:0]     target;
    logic [SYM_W-1:0]           from;
    logic [SYM_W-1:0]           to;
    logic                       busy;
    logic                       done;
    logic                       found;
    logic [SYM_W*NUM_CHARS-1:0] match;
`ifdef PWC_PROGRESS_COUNT_EN
    logic [31:0]                tried_count;
`endif
    modport master (
        output start, target, from, to,
        input  busy, done, found, match
`ifdef PWC_PROGRESS_COUNT_EN
        , input tried_count
`endif
    );
    modport slave (
        input  start, target, from, to,
        output busy, done, found, match
`ifdef PWC_PROGRESS_COUNT_EN
        , output tried_count
`endif
    );
endinterface

// File: rtl/password_cracker_engine.sv
// password_cracker_engine: brute-force sweep of NUM_CHARS-symbol candidates, LANES per clock.
// Define PWC_PROGRESS_COUNT_EN to add the saturating tried_count progress output.
module password_cracker_engine #(
    parameter int NUM_CHARS = 4,
    parameter int ALPHABET  = 36,
    parameter int SYM_W     = 6,
    parameter int LANES     = 1
) (
    input logic                      clk,
    input logic                      rst,
    password_cracker_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;
    localparam int MS = NUM_CHARS - 1;
    state_t                     state;
    logic [8*NUM_CHARS-1:0]     tgt;
    logic [SYM_W-1:0]           lo, hi;
    logic [SYM_W-1:0]           tsym [NUM_CHARS];
    logic [SYM_W-1:0]           base [NUM_CHARS];
    logic [SYM_W-1:0]           nxt [NUM_CHARS];
    logic [7:0]                 dsym [NUM_CHARS];
    logic [SYM_W*NUM_CHARS-1:0] tpack, match;
    logic                       busy, done, found, bad, carry, up_eq, mid_max, hit, last;
`ifdef PWC_PROGRESS_COUNT_EN
    logic [31:0]                tried;
    assign bus.tried_count = tried;
`endif
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.found = found;
    assign bus.match = match;
    // Unmapped characters decode to 8'hFF so a single range test rejects them.
    always_comb begin
        bad = (lo > hi) || ({1'b0, hi} >= (SYM_W + 1)'(ALPHABET));
        for (int i = 0; i < NUM_CHARS; i++) begin
            dsym[i] = (tgt[8*i +: 8] >= "0" && tgt[8*i +: 8] <= "9") ? tgt[8*i +: 8] - 8'd48 :
                      (tgt[8*i +: 8] >= "a" && tgt[8*i +: 8] <= "z") ? tgt[8*i +: 8] - 8'd87 : 8'hFF;
            bad = bad || (dsym[i] >= 8'(ALPHABET));
        end
    end
    // Lanes share the upper symbols, so at most one lane can hit: the one whose symbol 0 equals the target's.
    always_comb begin
        carry   = 1'b1;
        up_eq   = 1'b1;
        mid_max = 1'b1;
        tpack   = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            tpack[i*SYM_W +: SYM_W] = tsym[i];
            if (i == 0) begin
                nxt[i] = (base[i] == SYM_W'(ALPHABET - LANES)) ? '0 : base[i] + SYM_W'(LANES);
                carry  = base[i] == SYM_W'(ALPHABET - LANES);
            end else begin
                nxt[i] = carry ? ((base[i] == SYM_W'(ALPHABET - 1)) ? '0 : base[i] + SYM_W'(1)) : base[i];
                carry  = carry && (base[i] == SYM_W'(ALPHABET - 1));
                up_eq  = up_eq && (base[i] == tsym[i]);
            end
            if (i > 0 && i < MS)
                mid_max = mid_max && (base[i] == SYM_W'(ALPHABET - 1));
        end
        hit  = up_eq && (tsym[0] >= base[0]) &&
               ({1'b0, tsym[0]} < {1'b0, base[0]} + (SYM_W + 1)'(LANES));
        last = mid_max && (base[MS] == hi) && (base[0] == SYM_W'(ALPHABET - LANES));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            match <= '0;
            tgt   <= '0;
            lo    <= '0;
            hi    <= '0;
            base  <= '{default: '0};
            tsym  <= '{default: '0};
`ifdef PWC_PROGRESS_COUNT_EN
            tried <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state <= LOAD;
                    tgt   <= bus.target;
                    lo    <= bus.from;
                    hi    <= bus.to;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    found <= 1'b0;
                    match <= '0;
                end
                LOAD: begin
`ifdef PWC_PROGRESS_COUNT_EN
                    tried <= '0;
`endif
                    state <= bad ? DONE : SEARCH;
                    busy  <= !bad;
                    done  <= bad;
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        base[i] <= (i == MS) ? lo : '0;
                        tsym[i] <= dsym[i][SYM_W-1:0];
                    end
                end
                SEARCH: begin
`ifdef PWC_PROGRESS_COUNT_EN
                    tried <= (tried > 32'hFFFF_FFFF - 32'(LANES)) ? 32'hFFFF_FFFF : tried + 32'(LANES);
`endif
                    if (hit || last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        found <= hit;
                        match <= hit ? tpack : '0;
                    end else
                        base <= nxt;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_password_cracker_engine.sv
// tb_password_cracker_engine: directed jobs on a LANES=4 engine; a done-edge monitor scores results
// against expectations queued at issue time (found, match, latency from start edge, tried_count).
module tb_password_cracker_engine;
    typedef struct {
        logic        found;
        logic [23:0] match;
        int          lat;
        int          e;
        logic [31:0] tried;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    logic done_q = 1'b0;
    exp_t q[$];
    exp_t cur;
    password_cracker_engine_if #(.NUM_CHARS(4), .SYM_W(6)) bus();
    password_cracker_engine #(.NUM_CHARS(4), .ALPHABET(36), .SYM_W(6), .LANES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        done_q <= bus.done;
        if (bus.done && !done_q) begin
            if (q.size() == 0)
                chk("unexpected_done", 1, 0);
            else begin
                cur = q.pop_front();
                chk("found", bus.found, cur.found);
                chk("match", bus.match, cur.match);
                chk("latency", cyc - cur.e, cur.lat);
`ifdef PWC_PROGRESS_COUNT_EN
                chk("tried_count", bus.tried_count, cur.tried);
`endif
                popped++;
            end
        end
    end
    task automatic run(input logic [31:0] t, input int f, input int tt, input bit ef,
                       input logic [23:0] em, input int lat, input int tr, input int poke);
        int p0;
        p0 = popped;
        q.push_back('{ef, em, lat, cyc + 1, tr});
        bus.target = t;
        bus.from   = 6'(f);
        bus.to     = 6'(tt);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("done_cleared", bus.done, 0);
        for (int n = 0; n < lat + 10 && popped == p0; n++) begin
            bus.start  = (n == poke);
            bus.target = (n == poke) ? "0000" : t;
            bus.from   = (n == poke) ? 6'd0 : 6'(f);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (popped == p0)
            chk("done_timeout", 0, 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        bus.start  = 1'b0;
        bus.target = '0;
        bus.from   = '0;
        bus.to     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_found", bus.found, 0);
        chk("rst_match", bus.match, 0);
        rst = 1'b0;
        @(negedge clk);
        run("1003", 1, 1, 1'b1, 24'h040003, 2, 4, -1);
        run("000z", 0, 0, 1'b1, 24'h000023, 10, 36, 3);
        run("00A0", 0, 1, 1'b0, 24'h0, 1, 0, -1);
        run("1003", 5, 3, 1'b0, 24'h0, 1, 0, -1);
        run("1003", 0, 36, 1'b0, 24'h0, 1, 0, -1);
        run("000:", 0, 1, 1'b0, 24'h0, 1, 0, -1);
        run("zzzz", 35, 35, 1'b1, 24'h8E38E3, 11665, 46656, -1);
        run("2000", 0, 1, 1'b0, 24'h0, 23329, 93312, -1);
        bus.target = "2000";
        bus.from   = 6'd0;
        bus.to     = 6'd1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        chk("busy_mid_search", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
        chk("async_rst_found", bus.found, 0);
        chk("async_rst_match", bus.match, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("1003", 1, 1, 1'b1, 24'h040003, 2, 4, -1);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
